// File: rtl/cook_pkg.sv
// Shared cook-cycle definitions: the state encoding used by the run controller,
// the countdown timer and the display blocks.
package cook_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } cook_state_t;

endpackage

// File: rtl/cook_run_ctrl_req_edge_det.sv
// Rising-edge detector over a bus of level requests. any_rise is high when at
// least one bit went 0->1 since the previous clock; simultaneous edges merge.
module req_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic         any_rise
);

  logic [W-1:0] prev_q;

  // History register; reset loads the live level so a request held through
  // reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) prev_q <= level;
    else     prev_q <= level;
  end

  assign any_rise = |(level & ~prev_q);

endmodule

// File: rtl/cook_run_ctrl.sv
// Run/pause/cancel controller for the microwave cook cycle.
// Optional build macro COOK_DOOR_GATE_EN: when defined, heat is additionally
// gated combinationally by door_open so the magnetron stops in the same cycle
// the door opens; otherwise heat is purely registered.
module cook_run_ctrl
  import cook_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int DONE_CYCLES = 300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req_toggle,
  input  logic               req_cancel,
  input  logic               door_open,
  input  logic               timer_zero,
  input  logic               timer_end,
  output logic               heat,
  output logic               idle,
  output logic               paused,
  output logic               done,
  output logic               clr_time,
  output logic [STATE_W-1:0] state
);

  localparam int DONE_W = $clog2(DONE_CYCLES + 1);
  localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_CYCLES - 1);

  logic tog_ev, can_ev, door_rise;

  cook_state_t       state_q, state_d;
  logic [DONE_W-1:0] cnt_q, cnt_d;
  logic              clr_d;
  logic              heat_q, idle_q, paused_q, done_q, clr_q;

  req_edge_det #(.W(NUM_SRC)) u_tog_edge (
    .clk(clk), .rst(rst), .level(req_toggle), .any_rise(tog_ev)
  );

  req_edge_det #(.W(1)) u_can_edge (
    .clk(clk), .rst(rst), .level(req_cancel), .any_rise(can_ev)
  );

  // Door edge is only used to acknowledge DONE; level door_open drives the rest.
  req_edge_det #(.W(1)) u_door_edge (
    .clk(clk), .rst(rst), .level(door_open), .any_rise(door_rise)
  );

  // Next-state, done-hold counter and clear-pulse decode, in priority order
  // timer_end > door_open > cancel > toggle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (can_ev) clr_d = 1'b1;
        else if (tog_ev && !door_open && !timer_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (timer_end)      state_d = ST_DONE;
        else if (door_open) state_d = ST_PAUSE;
        else if (can_ev) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
        else if (tog_ev)    state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (timer_end) state_d = ST_DONE;
        else if (can_ev) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
        else if (tog_ev && !door_open) state_d = ST_RUN;
      end
      ST_DONE: begin
        // Timer is already zero here, so acknowledging needs no clear pulse.
        if (tog_ev || can_ev || door_rise || cnt_q == DONE_LAST) state_d = ST_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and registered output decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      heat_q   <= 1'b0;
      idle_q   <= 1'b1;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      heat_q   <= (state_d == ST_RUN);
      idle_q   <= (state_d == ST_IDLE);
      paused_q <= (state_d == ST_PAUSE);
      done_q   <= (state_d == ST_DONE);
      clr_q    <= clr_d;
    end
  end

`ifdef COOK_DOOR_GATE_EN
  assign heat = heat_q & ~door_open;
`else
  assign heat = heat_q;
`endif

  assign idle     = idle_q;
  assign paused   = paused_q;
  assign done     = done_q;
  assign clr_time = clr_q;
  assign state    = state_q;

endmodule
